// File: rtl/apb_mem_slave_ws.sv
// apb_mem_slave_ws: APB4 memory slave with programmable wait states,
// byte-lane write strobes and a registered read path.
// Optional feature macro: APB_SLVERR_EN. When it is defined, out-of-range
// accesses finish with pslverr=1, writes are dropped and reads return 0.
// When it is not defined, pslverr is tied low and out-of-range word indices
// wrap modulo MEM_DEPTH.

module apb_mem_slave_ws #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } stateT;

  stateT                 state;
  logic [3:0]            waitCnt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0]      wordIdx;
  logic [MEM_AW-1:0]     memIdx;
  logic [DATA_WIDTH-1:0] readData;
  logic                  writeOk;
  logic                  loadRdata;
  logic                  memWrite;

  // Word index drops the byte-offset bits; misaligned addresses are accepted.
  assign wordIdx = paddr[ADDR_WIDTH-1:LSB];
  // Modulo in one extra bit so MEM_DEPTH == 2**IDX_W does not become a zero divisor.
  assign memIdx  = MEM_AW'({1'b0, wordIdx} % (IDX_W + 1)'(MEM_DEPTH));

  // The transfer completes in ACCESS once the stall counter has run out.
  assign pready = (state == ACCESS) && psel && (waitCnt == 4'd0);

`ifdef APB_SLVERR_EN
  logic outOfRange;
  assign outOfRange = ({1'b0, wordIdx} >= (IDX_W + 1)'(MEM_DEPTH));
  assign pslverr    = pready && outOfRange;
  assign writeOk    = !outOfRange;
`else
  assign pslverr    = 1'b0;
  assign writeOk    = 1'b1;
`endif

  // Memory word presented to the read register; out-of-range reads see zero.
  always_comb begin
    // NOTE: assigning a default first keeps this block purely combinational;
    // a path that left readData unassigned would infer a latch.
    readData = mem[memIdx];
`ifdef APB_SLVERR_EN
    if (outOfRange) readData = '0;
`endif
  end

  // prdata is captured on the edge that enters the pready=1 cycle.
  assign loadRdata = psel &&
                     (((state == SETUP) && (WAIT_STATES == 0)) ||
                      ((state == ACCESS) && (waitCnt == 4'd1)));

  assign memWrite = pready && pwrite && writeOk && !prst;

  // Bus FSM, stall counter and read-data register.
  always_ff @(posedge pclk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (prst) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
      prdata  <= '0;
    end else begin
      if (loadRdata) prdata <= readData;
      case (state)
        IDLE: begin
          if (psel && !penable) state <= SETUP;
        end
        SETUP: begin
          if (psel) begin
            state   <= ACCESS;
            waitCnt <= WS_LOAD;
          end else begin
            state   <= IDLE;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (waitCnt != 4'd0) begin
            waitCnt <= waitCnt - 4'd1;
          end else if (!penable) begin
            state <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-lane write into the storage array in the completing cycle.
  always_ff @(posedge pclk) begin
    // NOTE: the array has no reset; contents survive prst and only the
    // control path is cleared, which keeps this mappable to RAM.
    if (memWrite) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (pstrb[i]) mem[memIdx][8*i +: 8] <= pwdata[8*i +: 8];
      end
    end
  end

endmodule
